// File: rtl/bcd_conv_arbiter_pkg.sv
// rtl/bcd_conv_arbiter_pkg.sv - state encoding and result width shared by the bcd_conv_arbiter slice
package bcd_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    START = S_START,
    WAIT  = S_WAIT,
    DONE  = S_DONE
  } state_t;

  localparam int BCD_W = 16;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - requester and converter bus of bcd_conv_arbiter
interface bcd_conv_arbiter_if
  import bcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 13
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] req_bin;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic [BCD_W-1:0]       bcd_out;
  logic                   busy;
  logic                   conv_ready;
  logic                   conv_start;
  logic [BIN_W-1:0]       conv_bin;
  logic                   conv_done_tick;
  logic [BCD_W-1:0]       conv_bcd;

  // master is the arbiter; slave is the requester/converter side
  modport master (
    input  req, req_bin, conv_ready, conv_done_tick, conv_bcd,
    output ack, err, bcd_out, busy, conv_start, conv_bin
  );

  modport slave (
    output req, req_bin, conv_ready, conv_done_tick, conv_bcd,
    input  ack, err, bcd_out, busy, conv_start, conv_bin
  );
endinterface

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// rtl/bcd_conv_arbiter_rr_pick.sv - combinational round-robin selector searching upward from ptr_i
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);
  int idx;

  // walk offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (req_i[idx]) begin
        grant_o = IDX_W'(idx);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one serial binary-to-BCD converter
// Optional WAIT watchdog enabled by defining BCD_ARB_WATCHDOG_EN.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = 13,
  parameter int TIMEOUT = 31
) (
  input logic                clk,
  input logic                reset,
  bcd_conv_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("bcd_conv_arbiter: unsupported N_REQ or TIMEOUT");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx;
  logic             pick_vld;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d, busy_q, busy_d, start_q, start_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;

`ifdef BCD_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d, wd_inc;
  assign wd_inc = wd_q + 1'b1;
`endif

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ack_d   = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
`ifdef BCD_ARB_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.conv_ready && pick_vld) begin
          grant_d = pick_idx;
          bin_d   = bus.req_bin[pick_idx*BIN_W +: BIN_W];
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef BCD_ARB_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      WAIT: begin
        // a done tick in the timeout cycle takes priority over the abort
        if (bus.conv_done_tick) begin
          bcd_d          = bus.conv_bcd;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
`ifdef BCD_ARB_WATCHDOG_EN
        else if (wd_inc == WD_W'(TIMEOUT)) begin
          bcd_d          = '0;
          err_d          = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          wd_d = wd_inc;
        end
`endif
      end
      DONE: begin
        ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef BCD_ARB_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
`ifdef BCD_ARB_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.busy       = busy_q;
  assign bus.conv_start = start_q;
  assign bus.conv_bin   = bin_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - scoreboard bench for bcd_conv_arbiter with a serial converter model
module tb_bcd_conv_arbiter;
  import bcd_pkg::*;

  localparam int N_REQ   = 4;
  localparam int BIN_W   = 13;
  localparam int TIMEOUT = 31;
  localparam int LAT     = 15;

  typedef struct {
    logic [N_REQ-1:0] ack;
    logic [15:0]      bcd;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.N_REQ(N_REQ), .BIN_W(BIN_W)) bus ();

  bcd_conv_arbiter #(.N_REQ(N_REQ), .BIN_W(BIN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // converter model: done tick LAT+1 cycles after the start cycle
  int          cnt;
  logic        tick_q, tick_en, ready_en, stray;
  logic [15:0] bcd_m;
  logic [BIN_W-1:0] op_m;

  function automatic logic [15:0] bin2bcd(input logic [BIN_W-1:0] v);
    int x = int'(v);
    logic [15:0] r = '0;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 0;
      tick_q <= 1'b0;
      bcd_m  <= '0;
      op_m   <= '0;
    end else begin
      tick_q <= 1'b0;
      if (bus.conv_start) begin
        cnt  <= LAT;
        op_m <= bus.conv_bin;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && tick_en) begin
          tick_q <= 1'b1;
          bcd_m  <= bin2bcd(op_m);
        end
      end
    end
  end

  assign bus.conv_ready     = ready_en && (cnt == 0) && !tick_q;
  assign bus.conv_done_tick = tick_q | stray;
  assign bus.conv_bcd       = stray ? 16'hDEAD : bcd_m;

  exp_t e;
  always @(negedge clk) begin
    if (bus.ack !== '0) begin
      ack_cyc = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack ack=%b bcd=%h err=%b", bus.ack, bus.bcd_out, bus.err);
      end else begin
        e = sb.pop_front();
        if (bus.ack !== e.ack || bus.bcd_out !== e.bcd || bus.err !== e.err) begin
          bad++;
          $display("FAIL sb_ack got ack=%b bcd=%h err=%b want ack=%b bcd=%h err=%b",
                   bus.ack, bus.bcd_out, bus.err, e.ack, e.bcd, e.err);
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [BIN_W-1:0] v);
    bus.req_bin[i*BIN_W +: BIN_W] = v;
  endtask

  task automatic push_exp(input int i, input logic [15:0] bcd, input logic err);
    exp_t x;
    x.ack = 4'b0001 << i;
    x.bcd = bcd;
    x.err = err;
    sb.push_back(x);
  endtask

  // acked requesters drop req, except during the first keep_n acks
  task automatic serve(input string name, input int budget, input int keep_n);
    int seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.ack !== '0) begin
        seen++;
        if (seen > keep_n) bus.req = bus.req & ~bus.ack;
      end
      if (sb.size() == 0 && bus.req == '0 && !bus.busy) return;
    end
    total++;
    bad++;
    $display("FAIL %s timeout pending=%0d busy=%b", name, sb.size(), bus.busy);
    bus.req = '0;
  endtask

  task automatic wait_start(input string name, output int at);
    at = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.conv_start === 1'b1) begin
        at = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s no_conv_start", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.ack !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl ack=%b err=%b busy=%b want 0", bus.ack, bus.err, bus.busy);
    end
    total++;
    if (bus.bcd_out !== 16'h0 || bus.conv_start !== 1'b0 || bus.conv_bin !== '0) begin
      bad++;
      $display("FAIL reset_data bcd=%h start=%b bin=%h want 0", bus.bcd_out, bus.conv_start, bus.conv_bin);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.conv_start !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req busy=%b start=%b want 0", bus.busy, bus.conv_start);
    end
  endtask

  task automatic test_single();
    int c0;
    @(negedge clk);
    set_op(0, 13'd4095);
    bus.req = 4'b0001;
    c0 = cyc;
    push_exp(0, 16'h4095, 1'b0);
    @(negedge clk);
    total++;
    if (bus.conv_start !== 1'b1 || bus.conv_bin !== 13'd4095 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL start_cycle start=%b bin=%0d busy=%b want 1 4095 1", bus.conv_start, bus.conv_bin, bus.busy);
    end
    @(negedge clk);
    total++;
    if (bus.conv_start !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse start=%b want 0", bus.conv_start);
    end
    serve("single", 100, 0);
    total++;
    if (ack_cyc - c0 != 18) begin
      bad++;
      $display("FAIL single_latency got=%0d want=18", ack_cyc - c0);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    set_op(0, 13'd1);
    set_op(1, 13'd22);
    set_op(2, 13'd333);
    set_op(3, 13'd4444);
    bus.req = 4'b1111;
    push_exp(0, 16'h0001, 1'b0);
    push_exp(1, 16'h0022, 1'b0);
    push_exp(2, 16'h0333, 1'b0);
    push_exp(3, 16'h4444, 1'b0);
    serve("all_four", 300, 0);
  endtask

  task automatic test_back_to_back_hold();
    int s;
    @(negedge clk);
    set_op(2, 13'd59);
    set_op(0, 13'd1234);
    bus.req = 4'b0100;
    wait_start("hold", s);
    bus.req = 4'b0101;
    push_exp(2, 16'h0059, 1'b0);
    push_exp(0, 16'h1234, 1'b0);
    push_exp(2, 16'h0059, 1'b0);
    push_exp(0, 16'h1234, 1'b0);
    serve("hold", 300, 2);
  endtask

  task automatic test_not_ready();
    @(negedge clk);
    ready_en = 1'b0;
    set_op(1, 13'd789);
    bus.req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.conv_start !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL not_ready_hold c=%0d start=%b busy=%b want 0", c, bus.conv_start, bus.busy);
      end
    end
    ready_en = 1'b1;
    push_exp(1, 16'h0789, 1'b0);
    serve("not_ready", 100, 0);
  endtask

  task automatic test_stray_tick();
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    total++;
    if (bus.ack !== '0 || bus.busy !== 1'b0 || bus.bcd_out !== 16'h0789) begin
      bad++;
      $display("FAIL stray_tick ack=%b busy=%b bcd=%h want 0 0 0789", bus.ack, bus.busy, bus.bcd_out);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    @(negedge clk);
    set_op(3, 13'd100);
    bus.req = 4'b1000;
    wait_start("reset_mid", s);
    repeat (5) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL wait_busy busy=%b want 1", bus.busy);
    end
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.bcd_out !== 16'h0 ||
        bus.conv_bin !== '0 || bus.conv_start !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid busy=%b ack=%b bcd=%h bin=%h start=%b err=%b want all 0",
               bus.busy, bus.ack, bus.bcd_out, bus.conv_bin, bus.conv_start, bus.err);
    end
    reset = 1'b0;
    @(negedge clk);
    set_op(0, 13'd5);
    set_op(3, 13'd6);
    bus.req = 4'b1001;
    push_exp(0, 16'h0005, 1'b0);
    push_exp(3, 16'h0006, 1'b0);
    serve("after_reset", 200, 0);
  endtask

`ifdef BCD_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int s;
    @(negedge clk);
    tick_en = 1'b0;
    set_op(2, 13'd321);
    bus.req = 4'b0100;
    push_exp(2, 16'h0000, 1'b1);
    wait_start("watchdog", s);
    serve("watchdog", 100, 0);
    total++;
    if (ack_cyc - s != TIMEOUT + 1) begin
      bad++;
      $display("FAIL watchdog_latency got=%0d want=%0d", ack_cyc - s, TIMEOUT + 1);
    end
    tick_en = 1'b1;
    set_op(3, 13'd999);
    bus.req = 4'b1000;
    push_exp(3, 16'h0999, 1'b0);
    serve("after_watchdog", 100, 0);
  endtask
`endif

  initial begin
    tick_en     = 1'b1;
    ready_en    = 1'b1;
    stray       = 1'b0;
    bus.req     = '0;
    bus.req_bin = '0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back_hold();
    test_not_ready();
    test_stray_tick();
    test_reset_mid();
`ifdef BCD_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
